// File: rtl/pipe_exe_md.sv
// pipe_exe_md: MIPS execute stage with operand forwarding, ALU, jal link path and iterative MUL/DIV.
// Latency: ALU/jal/MFHI/MFLO results are combinational; MULT/MULTU/DIV/DIVU take WIDTH cycles after issue.
// Backpressure: md_stall is raised while an MD op waits for the busy unit; ID/EXE must hold its inputs.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   ea, eb, eimm, epc4      operands, immediate (low bits = shift amount) and PC+4 from ID/EXE
//   malu, walu              forwarded results from MEM and WB
//   adepend, bdepend        operand select (A: ea/shamt/malu/walu, B: eb/eimm/malu/walu)
//   ealuc, emd              ALU op and multiply/divide op
//   evalid, ejal, ern0      slot valid, jal flag, destination register
//   ealu, ern, z            result, destination, ALU-result-is-zero
//   md_busy, md_stall       MD unit iterating, hold request to the hazard unit
module pipe_exe_md #(
  parameter int WIDTH    = 32,
  parameter int RADDR    = 5,
  parameter int LINK_REG = 31
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  input  logic [WIDTH-1:0] eimm,
  input  logic [WIDTH-1:0] epc4,
  input  logic [WIDTH-1:0] malu,
  input  logic [WIDTH-1:0] walu,
  input  logic [1:0]       adepend,
  input  logic [1:0]       bdepend,
  input  logic [3:0]       ealuc,
  input  logic [3:0]       emd,
  input  logic             evalid,
  input  logic             ejal,
  input  logic [RADDR-1:0] ern0,
  output logic [WIDTH-1:0] ealu,
  output logic [RADDR-1:0] ern,
  output logic             z,
  output logic             md_busy,
  output logic             md_stall
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [RADDR-1:0] LINK = RADDR'(LINK_REG);

  logic [WIDTH-1:0] alua, alub, alu_r;
  logic [SW-1:0]    shamt;

  // operand forwarding muxes
  always_comb begin
    alua = ea;
    case (adepend)
      2'd0: alua = ea;
      2'd1: alua = {{(WIDTH-SW){1'b0}}, eimm[SW-1:0]};
      2'd2: alua = malu;
      2'd3: alua = walu;
      default: alua = ea;
    endcase
  end

  always_comb begin
    alub = eb;
    case (bdepend)
      2'd0: alub = eb;
      2'd1: alub = eimm;
      2'd2: alub = malu;
      2'd3: alub = walu;
      default: alub = eb;
    endcase
  end

  assign shamt = alua[SW-1:0];

  always_comb begin
    alu_r = '0;
    case (ealuc)
      4'd0:  alu_r = alua + alub;
      4'd1:  alu_r = alua - alub;
      4'd2:  alu_r = alua & alub;
      4'd3:  alu_r = alua | alub;
      4'd4:  alu_r = alua ^ alub;
      4'd5:  alu_r = alub << (WIDTH / 2);
      4'd6:  alu_r = alub << shamt;
      4'd7:  alu_r = alub >> shamt;
      4'd8:  alu_r = WIDTH'($signed(alub) >>> shamt);
      4'd9:  alu_r = {{(WIDTH-1){1'b0}}, ($signed(alua) < $signed(alub))};
      4'd10: alu_r = {{(WIDTH-1){1'b0}}, (alua < alub)};
      default: alu_r = '0;
    endcase
  end

  assign z = (alu_r == '0);

  // ---------------- multiply / divide unit ----------------
  logic [WIDTH-1:0] hi, lo;
  logic [SW-1:0]    cnt;
  logic             is_div;   // in-flight op is a divide
  logic             res_neg;  // product / quotient must be negated
  logic             rem_neg;  // remainder takes the dividend's sign
  logic             dz;       // divide by zero
  // shared datapath: p_hi = product high half or partial remainder,
  // q = multiplier bits or dividend/quotient bits, dv = multiplicand or divisor
  logic [WIDTH-1:0] p_hi, q, dv;

  logic is_md, issue, start, sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_md    = evalid && (emd >= 4'd1) && (emd <= 4'd8);
  assign md_stall = is_md && md_busy;
  assign issue    = is_md && !md_busy;
  assign start    = issue && (emd <= 4'd4);
  assign sgn_op   = (emd == 4'd1) || (emd == 4'd3);
  assign a_neg    = sgn_op && alua[WIDTH-1];
  assign b_neg    = sgn_op && alub[WIDTH-1];
  assign mag_a    = a_neg ? -alua : alua;
  assign mag_b    = b_neg ? -alub : alub;

  // one iteration of shift-add multiply
  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] mul_hi_n, mul_q_n;
  assign msum     = {1'b0, p_hi} + (q[0] ? {1'b0, dv} : {(WIDTH+1){1'b0}});
  assign mul_hi_n = msum[WIDTH:1];
  assign mul_q_n  = {msum[0], q[WIDTH-1:1]};

  // one iteration of restoring divide; the subtraction only fits in WIDTH
  // bits when it succeeds, which is the only time its result is used
  logic             dge;
  logic [WIDTH-1:0] dshift, ddiff, div_hi_n, div_q_n;
  assign dge      = {p_hi, q[WIDTH-1]} >= {1'b0, dv};
  assign dshift   = {p_hi[WIDTH-2:0], q[WIDTH-1]};
  assign ddiff    = dshift - dv;
  assign div_hi_n = dge ? ddiff : dshift;
  assign div_q_n  = {q[WIDTH-2:0], dge};

  logic [WIDTH-1:0]   hi_n, q_n;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  assign hi_n   = is_div ? div_hi_n : mul_hi_n;
  assign q_n    = is_div ? div_q_n  : mul_q_n;
  assign prod   = {mul_hi_n, mul_q_n};
  assign prod_s = res_neg ? -prod : prod;

  always_comb begin
    fin_hi = prod_s[2*WIDTH-1:WIDTH];
    fin_lo = prod_s[WIDTH-1:0];
    if (is_div) begin
      fin_hi = rem_neg ? -div_hi_n : div_hi_n;
      fin_lo = dz ? {WIDTH{1'b1}} : (res_neg ? -div_q_n : div_q_n);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      md_busy <= 1'b0;
      cnt     <= '0;
      is_div  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      dz      <= 1'b0;
      p_hi    <= '0;
      q       <= '0;
      dv      <= '0;
    end else if (start) begin
      md_busy <= 1'b1;
      cnt     <= '0;
      is_div  <= (emd == 4'd3) || (emd == 4'd4);
      res_neg <= a_neg ^ b_neg;
      rem_neg <= a_neg;
      dz      <= (alub == '0);
      p_hi    <= '0;
      q       <= mag_a;
      dv      <= mag_b;
    end else if (issue && emd == 4'd7) begin
      hi <= alua;
    end else if (issue && emd == 4'd8) begin
      lo <= alua;
    end else if (md_busy) begin
      p_hi <= hi_n;
      q    <= q_n;
      cnt  <= cnt + SW'(1);
      if (&cnt) begin
        md_busy <= 1'b0;
        hi      <= fin_hi;
        lo      <= fin_lo;
      end
    end
  end

  // ---------------- result and destination ----------------
  always_comb begin
    ealu = alu_r;
    if (ejal)
      ealu = epc4 + WIDTH'(4);
    else if (emd == 4'd5)
      ealu = hi;
    else if (emd == 4'd6)
      ealu = lo;
  end

  assign ern = ejal ? LINK : ern0;

endmodule

// File: doc/pipe_exe_md.md
Name: pipe_exe_md

Overview:
- Parametrised execute stage for the pipelined MIPS CPU, replacing the 32-bit-only EXE block.
- Keeps operand forwarding (4:1 muxes), the ALU and the jal PC+8 path.
- Adds an iterative multiply/divide unit with architectural HI/LO registers, a busy flag and a pipeline stall request.
- Sits between the ID/EXE and EXE/MEM pipeline registers; md_stall feeds the hazard unit, which freezes PC, IF/ID and ID/EXE.

Parameters:
WIDTH, 32, datapath width; power of two, at least 8
RADDR, 5, register-number width
LINK_REG, 31, destination register forced by jal

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
ea  in  WIDTH  register operand A from ID/EXE
eb  in  WIDTH  register operand B from ID/EXE
eimm  in  WIDTH  extended immediate; eimm[log2(WIDTH)-1:0] is the shift amount
epc4  in  WIDTH  PC+4 of the instruction
malu  in  WIDTH  forwarded result from MEM
walu  in  WIDTH  forwarded result from WB
adepend  in  2  A select: 0 ea, 1 shift amount (zero-extended), 2 malu, 3 walu
bdepend  in  2  B select: 0 eb, 1 eimm, 2 malu, 3 walu
ealuc  in  4  ALU op
emd  in  4  MD op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 none
evalid  in  1  the EXE slot holds a real instruction (0 = bubble)
ejal  in  1  the instruction is jal
ern0  in  RADDR  destination register
ealu  out  WIDTH  EXE result
ern  out  RADDR  destination register
z  out  1  1 when the ALU result is zero
md_busy  out  1  the MD unit is iterating
md_stall  out  1  hold request to the hazard unit

Behaviour:
- Operand muxes:
  - alua/alub are selected per adepend/bdepend.
  - adepend=1 gives the shift amount taken from eimm[log2(WIDTH)-1:0], zero-extended.
- ALU (ealuc), all modulo 2^WIDTH:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 LUI: b << WIDTH/2
  - 6 SLL, 7 SRL, 8 SRA: b shifted by a[log2(WIDTH)-1:0]
  - 9 SLT signed, 10 SLTU; both return 0 or 1
  - 11-15 return 0
  - z = (ALU result == 0), independent of jal/MF selection.
- Result and destination:
  - ealu = epc4+4 if ejal; else HI if emd=5; else LO if emd=6; else ALU result.
  - ern = LINK_REG if ejal, else ern0.
- An MD op is "issued" when evalid=1, emd is in 1..8, and md_stall=0 in that cycle.
- md_stall = evalid & md_busy & (emd in 1..8).
  - ID/EXE holds its inputs while stalled.
  - The op is issued on the first cycle md_stall falls.
  - Non-MD instructions never stall.
- MTHI/MTLO: HI or LO <= alua at the issuing edge. Single cycle; md_busy stays 0.
- MFHI/MFLO read HI/LO combinationally. Issue cannot happen while busy, so the value read is always final.
- MULT/MULTU/DIV/DIVU start:
  - At the issue edge: capture the operand magnitudes and sign flags, clear the iteration counter, md_busy <= 1.
  - Iterate one bit per cycle for WIDTH cycles: shift-add for multiply, restoring division for divide.
  - At the edge ending iteration WIDTH, write HI/LO and set md_busy <= 0.
  - An op issued at edge N has its result visible after edge N+WIDTH; MFHI/MFLO may issue in the cycle following edge N+WIDTH.
- Multiply: {HI,LO} = 2·WIDTH-bit product. MULT is signed (two's-complement), MULTU is unsigned.
- Divide: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Divide corner cases:
  - Divisor 0: LO = all ones, HI = dividend, still WIDTH cycles.
  - Signed MIN / -1: LO = MIN, HI = 0.
- HI/LO change only at an MD completion edge, an MTHI/MTLO edge, or reset.
- Reset (any cycle, including mid-iteration):
  - HI=0, LO=0, md_busy=0, counter=0; the in-flight op is discarded.
  - md_stall then drops combinationally.
- MD ops issued back-to-back: the second stalls until the first completes; no queue.
- Combinational outputs: ealu, ern, z, md_stall.

Test Plan:
- Forwarding, WIDTH=32: ea=5, malu=7, walu=9; adepend=2, bdepend=3, ealuc=0 -> ealu=16, z=0. With ealuc=1, adepend=3, bdepend=3 -> ealu=0, z=1.
- jal: ejal=1, epc4=0x00400010, ern0=0 -> ealu=0x00400014, ern=31.
- MULT -3×7 issued at edge N -> md_busy high for 32 cycles, low after edge N+32, HI=0xFFFFFFFF, LO=0xFFFFFFEB. MFLO presented during busy -> md_stall=1 for each busy cycle, then ealu=0xFFFFFFEB.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=7. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- Reset asserted at iteration 10 of MULTU 0xFFFFFFFF×2 -> next cycle md_busy=0, HI=LO=0. MTLO 0x55 afterwards -> MFLO returns 0x55.
- WIDTH=16 build: MULTU 0xFFFF×0xFFFF -> HI=0xFFFE, LO=0x0001 after 16 cycles. SRA of 0x8000 by 15 -> 0xFFFF.
